// File: rtl/wishbone_board_mem_arb.sv
// N-port pipelined Wishbone slave over the board field RAM with round-robin, cycle-locked arbitration.
// Optional clear sweep of the whole board is compiled in with WB_BOARD_MEM_CLEAR_EN.
module wishbone_board_mem_arb #(
    parameter int N_MASTERS = 3,
    parameter int ROWS      = 16,
    parameter int COLS      = 16,
    parameter int RW        = 4,
    parameter int CW        = 4,
    parameter int DW        = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          cyc_i,
    input  logic [N_MASTERS-1:0]          stb_i,
    input  logic [N_MASTERS-1:0]          we_i,
    input  logic [N_MASTERS*(RW+CW)-1:0]  adr_i,
    input  logic [N_MASTERS*DW-1:0]       dat_i,
    output logic [N_MASTERS*DW-1:0]       dat_o,
    output logic [N_MASTERS-1:0]          ack_o,
    output logic [N_MASTERS-1:0]          err_o,
`ifdef WB_BOARD_MEM_CLEAR_EN
    input  logic                          clear_i,
    output logic                          clear_done_o,
`endif
    output logic [N_MASTERS-1:0]          stall_o
);
    localparam int AW = RW + CW;
    localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam logic [RW:0] ROWS_L = ROWS[RW:0];
    localparam logic [CW:0] COLS_L = COLS[CW:0];
    localparam logic [GW:0] N_L    = N_MASTERS[GW:0];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT
`ifdef WB_BOARD_MEM_CLEAR_EN
        , ST_CLEAR
`endif
    } state_t;

`ifdef WB_BOARD_MEM_CLEAR_EN
    localparam state_t ST_RESET = ST_CLEAR;
`else
    localparam state_t ST_RESET = ST_IDLE;
`endif

    state_t                  state_q, state_d;
    logic [GW-1:0]           gnt_q, gnt_d;
    logic [GW-1:0]           rr_q, rr_d;
    logic [N_MASTERS-1:0]    ack_q, err_q;
    logic [N_MASTERS*DW-1:0] dat_q;

    // Storage is indexed by {row, col}; unused cells exist when ROWS/COLS are not powers of two.
    logic [DW-1:0] mem_q [2**AW];
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;

    logic [AW-1:0] adr_a  [N_MASTERS];
    logic [DW-1:0] wdat_a [N_MASTERS];
    logic [AW-1:0] adr_g;
    logic          acc, in_rng;
    logic          req_any;
    logic [GW-1:0] req_pick;

    always_comb begin
        for (int k = 0; k < N_MASTERS; k++) begin
            adr_a[k]  = adr_i[k*AW +: AW];
            wdat_a[k] = dat_i[k*DW +: DW];
        end
    end

    assign adr_g  = adr_a[gnt_q];
    assign in_rng = ({1'b0, adr_g[AW-1:CW]} < ROWS_L) && ({1'b0, adr_g[CW-1:0]} < COLS_L);
    assign acc    = (state_q == ST_GRANT) && cyc_i[gnt_q] && stb_i[gnt_q];

    // First requester at or after the round-robin pointer.
    always_comb begin
        logic [GW:0] cand;
        cand     = '0;
        req_any  = 1'b0;
        req_pick = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            cand = {1'b0, rr_q} + (GW+1)'(i);
            if (cand >= N_L) cand = cand - N_L;
            if (!req_any && cyc_i[cand[GW-1:0]]) begin
                req_any  = 1'b1;
                req_pick = cand[GW-1:0];
            end
        end
    end

    always_comb begin
        stall_o = '1;
        if (state_q == ST_GRANT) stall_o[gnt_q] = 1'b0;
    end

`ifdef WB_BOARD_MEM_CLEAR_EN
    localparam logic [RW-1:0] ROWS_M1 = RW'(ROWS - 1);
    localparam logic [CW-1:0] COLS_M1 = CW'(COLS - 1);
    logic [RW-1:0] clr_row_q, clr_row_d;
    logic [CW-1:0] clr_col_q, clr_col_d;
    logic          clr_pend_q, clr_pend_d;
    logic          done_q, done_d;
`endif

    always_comb begin
        logic [GW:0] rr_nxt;
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        rr_nxt  = {1'b0, gnt_q} + (GW+1)'(1);
        mem_we  = acc && we_i[gnt_q] && in_rng;
        mem_wa  = adr_g;
        mem_wd  = wdat_a[gnt_q];
`ifdef WB_BOARD_MEM_CLEAR_EN
        clr_row_d  = clr_row_q;
        clr_col_d  = clr_col_q;
        done_d     = 1'b0;
        // A clear request during a locked cycle waits for the release.
        clr_pend_d = clr_pend_q | (clear_i && (state_q == ST_GRANT));
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef WB_BOARD_MEM_CLEAR_EN
                if (clear_i || clr_pend_q) begin
                    state_d    = ST_CLEAR;
                    clr_pend_d = 1'b0;
                end else
`endif
                if (req_any) begin
                    state_d = ST_GRANT;
                    gnt_d   = req_pick;
                end
            end
            ST_GRANT: begin
                if (!cyc_i[gnt_q]) begin
                    state_d = ST_IDLE;
                    rr_d    = (rr_nxt == N_L) ? '0 : rr_nxt[GW-1:0];
                end
            end
`ifdef WB_BOARD_MEM_CLEAR_EN
            ST_CLEAR: begin
                mem_we = 1'b1;
                mem_wa = {clr_row_q, clr_col_q};
                mem_wd = '0;
                if (clr_col_q == COLS_M1) begin
                    clr_col_d = '0;
                    if (clr_row_q == ROWS_M1) begin
                        clr_row_d = '0;
                        state_d   = ST_IDLE;
                        done_d    = 1'b1;
                    end else begin
                        clr_row_d = clr_row_q + RW'(1);
                    end
                end else begin
                    clr_col_d = clr_col_q + CW'(1);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RESET;
            gnt_q   <= '0;
            rr_q    <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            ack_q   <= '0;
            err_q   <= '0;
            if (acc) begin
                ack_q[gnt_q] <= in_rng;
                err_q[gnt_q] <= !in_rng;
                if (!we_i[gnt_q]) dat_q[gnt_q*DW +: DW] <= in_rng ? mem_q[adr_g] : '0;
            end
        end
    end

`ifdef WB_BOARD_MEM_CLEAR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_row_q  <= '0;
            clr_col_q  <= '0;
            clr_pend_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            clr_row_q  <= clr_row_d;
            clr_col_q  <= clr_col_d;
            clr_pend_q <= clr_pend_d;
            done_q     <= done_d;
        end
    end

    assign clear_done_o = done_q;
`endif

    assign dat_o = dat_q;
    assign ack_o = ack_q;
    assign err_o = err_q;
endmodule

// File: tb/tb_wishbone_board_mem_arb.sv
// Directed bench for wishbone_board_mem_arb: a 16x16 board and a 10x10 board driven by the same masters.
// Define WB_BOARD_MEM_CLEAR_EN to include the clear sweep tests.
module tb_wishbone_board_mem_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  cyc = '0, stb = '0, we = '0;
    logic [23:0] adr = '0;
    logic [23:0] dat_w = '0;
    logic [23:0] dat_r, dat_r10;
    logic [2:0]  ack, err, stall, ack10, err10, stall10;
`ifdef WB_BOARD_MEM_CLEAR_EN
    logic        clear = 1'b0;
    logic        clear_done, clear_done10;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    wishbone_board_mem_arb u_dut (
        .clk(clk), .rst(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr), .dat_i(dat_w),
        .dat_o(dat_r), .ack_o(ack), .err_o(err),
`ifdef WB_BOARD_MEM_CLEAR_EN
        .clear_i(clear), .clear_done_o(clear_done),
`endif
        .stall_o(stall)
    );

    wishbone_board_mem_arb #(.ROWS(10), .COLS(10)) u_dut10 (
        .clk(clk), .rst(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr), .dat_i(dat_w),
        .dat_o(dat_r10), .ack_o(ack10), .err_o(err10),
`ifdef WB_BOARD_MEM_CLEAR_EN
        .clear_i(clear), .clear_done_o(clear_done10),
`endif
        .stall_o(stall10)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        int n;
        cyc = '0; stb = '0; we = '0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
`ifdef WB_BOARD_MEM_CLEAR_EN
        n = 0;
        while (!clear_done && n < 400) begin
            tick();
            n++;
        end
        check_eq("reset_clear_done", clear_done, 1'b1);
        check_eq("reset_clear10_idle", clear_done10, 1'b0);
`else
        n = 0;
`endif
        tick();
    endtask

    // Single locked transfer: wait for grant, one accept, sample the response, release.
    task automatic wb_xfer(input int m, input bit w, input logic [7:0] a, input logic [7:0] d,
                           output logic r_ack, output logic r_err, output logic [7:0] r_dat,
                           output logic r_ack10, output logic r_err10, output logic [7:0] r_dat10);
        int n;
        n = 0;
        cyc[m] = 1'b1; stb[m] = 1'b1; we[m] = w;
        adr[m*8 +: 8] = a; dat_w[m*8 +: 8] = d;
        while (stall[m] && n < 50) begin
            tick();
            n++;
        end
        check_eq("xfer_grant", stall[m], 1'b0);
        tick();
        stb[m] = 1'b0; cyc[m] = 1'b0;
        r_ack = ack[m]; r_err = err[m]; r_dat = dat_r[m*8 +: 8];
        r_ack10 = ack10[m]; r_err10 = err10[m]; r_dat10 = dat_r10[m*8 +: 8];
        tick();
    endtask

    // Back-to-back burst at consecutive addresses; reads are scored against exp_q.
    task automatic wb_burst(input int m, input bit w, input logic [7:0] start, input int n,
                            input logic [7:0] dbase, input logic [7:0] dstep,
                            output int acks, output int stall_bad);
        int t;
        logic [7:0] exp_d;
        t = 0; acks = 0; stall_bad = 0;
        cyc[m] = 1'b1; stb[m] = 1'b1; we[m] = w;
        adr[m*8 +: 8] = start; dat_w[m*8 +: 8] = dbase;
        while (stall[m] && t < 50) begin
            tick();
            t++;
        end
        check_eq("burst_grant", stall[m], 1'b0);
        for (int i = 0; i < n; i++) begin
            adr[m*8 +: 8]   = start + 8'(i);
            dat_w[m*8 +: 8] = dbase + 8'(i) * dstep;
            tick();
            if ((stall | (3'b001 << m)) != 3'b111) stall_bad++;
            if (ack[m]) begin
                acks++;
                if (!w) begin
                    if (exp_q.size() != 0) exp_d = exp_q.pop_front();
                    else exp_d = 'x;
                    check_eq("burst_rd", dat_r[m*8 +: 8], exp_d);
                end
            end
        end
        stb[m] = 1'b0; cyc[m] = 1'b0;
        tick();
        check_eq("burst_ack_tail", ack[m], 1'b0);
        tick();
    endtask

    initial begin
        logic       a_, e_, a10, e10;
        logic [7:0] d_, d10;
        int         n, acks, sbad, bad;
        int         ord_q[$];

        // Reset state while rst is held
        repeat (2) tick();
        check_eq("rst_ack", ack, 3'b000);
        check_eq("rst_err", err, 3'b000);
        check_eq("rst_dat", dat_r, 24'h0);
        check_eq("rst_stall", stall, 3'b111);
        do_reset();

        // 1: write then read on M0
        wb_xfer(0, 1'b1, 8'h35, 8'h2A, a_, e_, d_, a10, e10, d10);
        check_eq("t1_wr_ack", a_, 1'b1);
        check_eq("t1_wr_err", e_, 1'b0);
        check_eq("t1_ack_width", ack[0], 1'b0);
        wb_xfer(0, 1'b0, 8'h35, 8'h00, a_, e_, d_, a10, e10, d10);
        check_eq("t1_rd_ack", a_, 1'b1);
        check_eq("t1_rd_dat", d_, 8'h2A);

        // 2: three simultaneous requesters from rr_ptr=0
        do_reset();
        cyc = 3'b111; stb = 3'b111; we = 3'b111;
        adr = {8'h52, 8'h51, 8'h50};
        dat_w = {8'hC2, 8'hB1, 8'hA0};
        tick();
        check_eq("t2_stall_first", stall, 3'b110);
        n = 0; bad = 0;
        while (cyc != 3'b000 && n < 40) begin
            tick();
            n++;
            if (stall != 3'b111 && !$onehot(~stall)) bad++;
            for (int j = 0; j < 3; j++) begin
                if (ack[j]) begin
                    ord_q.push_back(j);
                    cyc[j] = 1'b0; stb[j] = 1'b0;
                end
            end
        end
        check_eq("t2_single_grant", bad, 0);
        check_eq("t2_order_cnt", ord_q.size(), 3);
        for (int i = 0; i < ord_q.size(); i++) check_eq($sformatf("t2_order%0d", i), ord_q[i], i);
        tick();
        wb_xfer(0, 1'b0, 8'h50, 8'h00, a_, e_, d_, a10, e10, d10);
        check_eq("t2_rd_m0", d_, 8'hA0);
        wb_xfer(0, 1'b0, 8'h51, 8'h00, a_, e_, d_, a10, e10, d10);
        check_eq("t2_rd_m1", d_, 8'hB1);
        wb_xfer(0, 1'b0, 8'h52, 8'h00, a_, e_, d_, a10, e10, d10);
        check_eq("t2_rd_m2", d_, 8'hC2);
        check_eq("t2_rd_m2_10", d10, 8'hC2);

        // 3: M1 back-to-back bursts
        wb_burst(1, 1'b1, 8'h60, 10, 8'h10, 8'h01, acks, sbad);
        check_eq("t3_wr_acks", acks, 10);
        check_eq("t3_wr_stall", sbad, 0);
        for (int i = 0; i < 10; i++) exp_q.push_back(8'h10 + 8'(i));
        wb_burst(1, 1'b0, 8'h60, 10, 8'h00, 8'h00, acks, sbad);
        check_eq("t3_rd_acks", acks, 10);
        check_eq("t3_rd_stall", sbad, 0);
        check_eq("t3_exp_left", exp_q.size(), 0);

        // 4: out-of-range on the 10x10 board
        wb_xfer(0, 1'b0, 8'hAB, 8'h00, a_, e_, d_, a10, e10, d10);
        check_eq("t4_rd_err10", e10, 1'b1);
        check_eq("t4_rd_ack10", a10, 1'b0);
        check_eq("t4_rd_dat10", d10, 8'h00);
        check_eq("t4_rd_ack16", a_, 1'b1);
        check_eq("t4_stall10", stall10, 3'b111);
        wb_xfer(0, 1'b1, 8'hAB, 8'hC3, a_, e_, d_, a10, e10, d10);
        check_eq("t4_wr_err10", e10, 1'b1);
        check_eq("t4_wr_ack10", a10, 1'b0);
        wb_xfer(0, 1'b0, 8'hAB, 8'h00, a_, e_, d_, a10, e10, d10);
        check_eq("t4_rd16_dat", d_, 8'hC3);
        check_eq("t4_rd2_dat10", d10, 8'h00);
        wb_xfer(0, 1'b0, 8'h1A, 8'h00, a_, e_, d_, a10, e10, d10);
        check_eq("t4_col_err10", e10, 1'b1);
        wb_xfer(0, 1'b1, 8'h99, 8'h5A, a_, e_, d_, a10, e10, d10);
        wb_xfer(0, 1'b0, 8'h99, 8'h00, a_, e_, d_, a10, e10, d10);
        check_eq("t4_corner_ack10", a10, 1'b1);
        check_eq("t4_corner_dat10", d10, 8'h5A);

        // 5: async reset while a read ack is outstanding
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[7:0] = 8'h99;
        n = 0;
        while (stall[0] && n < 50) begin
            tick();
            n++;
        end
        tick();
        check_eq("t5_ack_pre", ack[0], 1'b1);
        #2 rst = 1'b1;
        #1;
        check_eq("t5_ack_cancel", ack, 3'b000);
        check_eq("t5_stall_all", stall, 3'b111);
        check_eq("t5_dat_zero", dat_r, 24'h0);
        do_reset();
        wb_xfer(2, 1'b1, 8'h33, 8'h77, a_, e_, d_, a10, e10, d10);
        check_eq("t5_wr_ack", a_, 1'b1);
        wb_xfer(2, 1'b0, 8'h33, 8'h00, a_, e_, d_, a10, e10, d10);
        check_eq("t5_rd_ack", a_, 1'b1);
        check_eq("t5_rd_dat", d_, 8'h77);

`ifdef WB_BOARD_MEM_CLEAR_EN
        // 6: fill with 0xFF, clear, read everything back as zero
        wb_burst(0, 1'b1, 8'h00, 256, 8'hFF, 8'h00, acks, sbad);
        check_eq("t6_fill_acks", acks, 256);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("t6_stall_clear", stall, 3'b111);
        n = 0;
        while (!clear_done && n < 400) begin
            tick();
            n++;
        end
        check_eq("t6_clear_cycles", n, 256);
        tick();
        check_eq("t6_done_width", clear_done, 1'b0);
        for (int i = 0; i < 256; i++) exp_q.push_back(8'h00);
        wb_burst(0, 1'b0, 8'h00, 256, 8'h00, 8'h00, acks, sbad);
        check_eq("t6_rd_acks", acks, 256);
        check_eq("t6_exp_left", exp_q.size(), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
